uart_tx: RTL and testbench



---
 rtl/uart_tx.sv | 155 +++++++++++++++
 tb/tb_uart_tx.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO on a valid/ready push interface.
// Each bit is held for CLKS_PER_BIT cycles; back-to-back frames have no idle gap.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tx_valid,
  input  logic [7:0]                    tx_data,
  output logic                          tx_ready,
  output logic                          io_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL     = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   bit_cnt_q;
  logic [2:0]      idx_q;
  logic [7:0]      shift_q;
  logic            tx_q;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     count_q;
  logic [AW:0]     count_d;

  logic            push;
  logic            pop;
  logic            bit_done;
  logic            fifo_empty;

  assign fifo_empty = (count_q == '0);
  assign bit_done   = (bit_cnt_q == BIT_LAST);
  assign tx_ready   = (count_q != FULL);
  assign push       = tx_valid && tx_ready;
  // Pop in IDLE, or on the final stop-bit cycle so the next start bit follows with no gap.
  assign pop        = !fifo_empty && ((state_q == IDLE) || ((state_q == STOP) && bit_done));

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          tx_q      <= 1'b1;
          bit_cnt_q <= '0;
          idx_q     <= '0;
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
            state_q <= START;
            tx_q    <= 1'b0;
          end
        end
        START: begin
          if (bit_done) begin
            bit_cnt_q <= '0;
            idx_q     <= '0;
            state_q   <= DATA;
            tx_q      <= shift_q[0];
          end else begin
            bit_cnt_q <= bit_cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (bit_done) begin
            bit_cnt_q <= '0;
            if (idx_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              idx_q <= idx_q + 3'd1;
              tx_q  <= shift_q[idx_q + 3'd1];
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (bit_done) begin
            bit_cnt_q <= '0;
            idx_q     <= '0;
            if (pop) begin
              shift_q <= mem_q[rd_ptr_q];
              state_q <= START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign io_tx      = tx_q;
  assign busy       = (state_q != IDLE) || !fifo_empty;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4) with a line-side frame decoder.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_ready;
  logic       io_tx;
  logic       busy;
  logic [2:0] fifo_count;

  int n_checks = 0;
  int n_errors = 0;
  int edges = 0;

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .io_tx      (io_tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line decoder: samples io_tx mid-cycle, checks each bit is held CPB cycles.
  logic [7:0] q_data[$];
  int         q_gap[$];
  bit         q_ok[$];
  int         q_start[$];

  initial begin
    int mst, k, idle_run, st, gap_hold, b;
    logic [7:0] sh;
    bit fok;
    mst = 0; k = 0; idle_run = 0; st = 0; gap_hold = 0; sh = '0; fok = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mst = 0;
        idle_run = 0;
      end else if (mst == 0) begin
        if (io_tx === 1'b0) begin
          mst = 1; k = 1; fok = 1'b1; sh = '0; st = edges; gap_hold = idle_run;
        end else begin
          idle_run++;
        end
      end else begin
        if (k < CPB) begin
          if (io_tx !== 1'b0) fok = 1'b0;
        end else if (k < 9 * CPB) begin
          b = (k - CPB) / CPB;
          if ((k - CPB) % CPB == 0) sh[b] = io_tx;
          else if (io_tx !== sh[b]) fok = 1'b0;
        end else if (io_tx !== 1'b1) begin
          fok = 1'b0;
        end
        if (k == FRAME - 1) begin
          q_data.push_back(sh);
          q_gap.push_back(gap_hold);
          q_ok.push_back(fok);
          q_start.push_back(st);
          mst = 0;
          idle_run = 0;
        end else begin
          k++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, output int acc_edge);
    logic r;
    tx_valid = 1'b1;
    tx_data  = d;
    acc_edge = -1;
    for (int i = 0; i < 400 && acc_edge < 0; i++) begin
      r = tx_ready;
      step();
      if (r) acc_edge = edges;
    end
    check("push_accepted", acc_edge >= 0, 1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 2000 && busy; i++) step();
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic wait_frames(input string tag, input int n);
    for (int i = 0; i < n * FRAME + 400 && q_data.size() < n; i++) step();
    check({tag, "_nframes"}, q_data.size() >= n, 1);
  endtask

  task automatic get_frame(output logic [7:0] d, output int gap, output bit ok, output int st);
    if (q_data.size() > 0) begin
      d = q_data.pop_front(); gap = q_gap.pop_front();
      ok = q_ok.pop_front();  st = q_start.pop_front();
    end else begin
      d = '0; gap = -1; ok = 1'b0; st = -1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nN, acc, prev_st, gap, st, lows, bad;
    int acc6[6];
    logic [7:0] d;
    logic [7:0] b2b[3];
    logic [7:0] exp_q[$];
    bit ok;

    b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'h55;

    // Reset state
    repeat (3) step();
    check("rst_io", io_tx, 1);
    check("rst_busy", busy, 0);
    check("rst_cnt", fifo_count, 0);
    check("rst_ready", tx_ready, 1);
    reset = 1'b0;
    step();

    // Single byte 0xA5
    tx_valid = 1'b1; tx_data = 8'hA5;
    check("t1_ready", tx_ready, 1);
    step();
    nN = edges;
    tx_valid = 1'b0;
    check("t1_cnt_n", fifo_count, 1);
    check("t1_io_n", io_tx, 1);
    check("t1_busy_n", busy, 1);
    step();
    check("t1_cnt_n1", fifo_count, 0);
    check("t1_start", io_tx, 0);
    while (edges < nN + CPB) step();
    check("t1_start_last", io_tx, 0);
    step();
    check("t1_bit0", io_tx, 1);
    while (edges < nN + CPB + 1 + CPB) step();
    check("t1_bit1", io_tx, 0);
    while (edges < nN + FRAME) step();
    check("t1_stop_busy", busy, 1);
    check("t1_stop_io", io_tx, 1);
    step();
    check("t1_busy_fall", busy, 0);
    check("t1_idle_io", io_tx, 1);
    wait_frames("t1", 1);
    get_frame(d, gap, ok, st);
    check("t1_byte", d, 8'hA5);
    check("t1_ok", ok, 1);
    check("t1_start_edge", st, nN + 1);

    // Back-to-back 0x00, 0xFF, 0x55
    wait_idle("t2");
    tx_valid = 1'b1; tx_data = 8'h00;
    step();
    nN = edges;
    tx_data = 8'hFF; step();
    tx_data = 8'h55; step();
    tx_valid = 1'b0;
    check("t2_cnt", fifo_count, 2);
    wait_frames("t2", 3);
    prev_st = 0;
    for (int i = 0; i < 3; i++) begin
      get_frame(d, gap, ok, st);
      check("t2_byte", d, b2b[i]);
      check("t2_ok", ok, 1);
      if (i == 0) check("t2_first_start", st, nN + 1);
      else begin
        check("t2_gap", gap, 0);
        check("t2_contig", st, prev_st + FRAME);
      end
      prev_st = st;
    end

    // Full FIFO with held tx_valid
    wait_idle("t3");
    for (int i = 0; i < 6; i++) begin
      push(8'(i + 1), acc6[i]);
      if (i == 4) begin
        check("t3_full_cnt", fifo_count, 4);
        check("t3_full_ready", tx_ready, 0);
      end
    end
    tx_valid = 1'b0;
    check("t3_acc5", acc6[4] - acc6[0], 4);
    check("t3_acc6", acc6[5] - acc6[0], 42);
    wait_frames("t3", 6);
    for (int i = 0; i < 6; i++) begin
      get_frame(d, gap, ok, st);
      check("t3_byte", d, 8'(i + 1));
      check("t3_ok", ok, 1);
      if (i > 0) check("t3_gap", gap, 0);
    end

    // Reset mid-frame, with a queued byte and a push on the reset cycle
    wait_idle("t4");
    check("t4_q_empty", q_data.size(), 0);
    push(8'h3C, nN);
    push(8'h99, acc);
    tx_valid = 1'b0;
    check("t4_cnt_pre", fifo_count, 1);
    while (edges < nN + 15) step();
    check("t4_bit2", io_tx, 1);
    reset = 1'b1; tx_valid = 1'b1; tx_data = 8'h77;
    step();
    reset = 1'b0; tx_valid = 1'b0;
    check("t4_io", io_tx, 1);
    check("t4_cnt", fifo_count, 0);
    check("t4_busy", busy, 0);
    check("t4_ready", tx_ready, 1);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (io_tx !== 1'b1) lows++;
    end
    check("t4_line_quiet", lows, 0);
    check("t4_no_frames", q_data.size(), 0);
    push(8'h81, acc);
    tx_valid = 1'b0;
    wait_frames("t4", 1);
    get_frame(d, gap, ok, st);
    check("t4_byte", d, 8'h81);
    check("t4_ok", ok, 1);
    wait_idle("t4b");
    check("t4_only_one", q_data.size(), 0);

    // Loopback-style stream of random bytes with random gaps
    for (int i = 0; i < 256; i++) begin
      int g;
      tx_valid = 1'b0;
      g = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) g = $urandom_range(10, 80);
      repeat (g) step();
      d = 8'($urandom);
      push(d, acc);
      exp_q.push_back(d);
    end
    tx_valid = 1'b0;
    wait_frames("t5", 256);
    wait_idle("t5");
    check("t5_count", q_data.size(), 256);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      get_frame(d, gap, ok, st);
      if (!ok) bad++;
      check("t5_byte", d, e);
    end
    check("t5_bad_frames", bad, 0);

    // Push coinciding with the STOP->START pop edge at fifo_count=2
    wait_idle("t6");
    tx_valid = 1'b1; tx_data = 8'h11;
    step();
    nN = edges;
    tx_data = 8'h22; step();
    tx_data = 8'h33; step();
    tx_valid = 1'b0;
    check("t6_cnt", fifo_count, 2);
    while (edges < nN + FRAME) step();
    check("t6_cnt_pre", fifo_count, 2);
    tx_valid = 1'b1; tx_data = 8'h44;
    check("t6_ready", tx_ready, 1);
    step();
    tx_valid = 1'b0;
    check("t6_cnt_post", fifo_count, 2);
    check("t6_start", io_tx, 0);
    wait_frames("t6", 4);
    for (int i = 0; i < 4; i++) begin
      get_frame(d, gap, ok, st);
      check("t6_byte", d, 8'(8'h11 * (i + 1)));
      check("t6_ok", ok, 1);
      if (i > 0) check("t6_gap", gap, 0);
    end
    wait_idle("t6b");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
